// File: rtl/hbridge_deadtime_if.sv
// Signal bundle between the PWM/control side and the H-bridge dead-time stage.
// The master drives the commands; the slave (the bridge stage) drives the gate and status outputs.
interface hbridge_deadtime_if;
    logic       pwm_in;
    logic       enable;
    logic       dir;
    logic       brake;
    logic       fault;
    logic       fault_clr;
    logic       a_hi;
    logic       a_lo;
    logic       b_hi;
    logic       b_lo;
    logic [1:0] state;
    logic       fault_latched;

    modport master (
        output pwm_in, enable, dir, brake, fault, fault_clr,
        input  a_hi, a_lo, b_hi, b_lo, state, fault_latched
    );

    modport slave (
        input  pwm_in, enable, dir, brake, fault, fault_clr,
        output a_hi, a_lo, b_hi, b_lo, state, fault_latched
    );
endinterface

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver: turns PWM/direction/brake/enable into four gate drives with per-leg
// dead time, an all-off gap on start-up and reversal, and a sticky fault latch.
module hbridge_deadtime #(
    parameter int DEADTIME = 2,
    parameter int DIR_GAP  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    hbridge_deadtime_if.slave bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_BRAKE = 2'd3
    } state_t;

    // Leg encoding doubles as the gate drive: bit 1 = high FET, bit 0 = low FET.
    typedef enum logic [1:0] {
        LEG_Z = 2'b00,
        LEG_L = 2'b01,
        LEG_H = 2'b10
    } leg_t;

    typedef struct packed {
        leg_t       out;
        logic [3:0] dt;
    } leg_st_t;

    localparam logic [3:0] DT_LOAD  = 4'(DEADTIME - 1);
    localparam logic [7:0] GAP_LOAD = 8'(DIR_GAP - 1);

    state_t     state_q, state_d;
    logic       dir_q, dir_d;
    logic [7:0] gap_q, gap_d;
    logic       fault_q, fault_d;
    leg_t       a_cmd, b_cmd;
    leg_st_t    a_q, a_d;
    leg_st_t    b_q, b_d;

    // One dead-time step for a leg; the off-going FET always drops immediately.
    function automatic leg_st_t leg_step(input leg_t cmd, input leg_st_t cur);
        leg_st_t nxt;
        nxt = cur;
        if (cmd == LEG_Z) begin
            nxt.out = LEG_Z;
            if (cur.out != LEG_Z) begin
                nxt.dt = DT_LOAD;
            end else if (cur.dt != 4'd0) begin
                nxt.dt = cur.dt - 4'd1;
            end
        end else if (cur.out != LEG_Z) begin
            if (cmd != cur.out) begin
                nxt.out = LEG_Z;
                nxt.dt  = DT_LOAD;
            end
        end else if (cur.dt == 4'd0) begin
            nxt.out = cmd;
        end else begin
            nxt.dt = cur.dt - 4'd1;
        end
        return nxt;
    endfunction

    always_comb begin
        fault_d = fault_q;
        if (bus.fault) begin
            fault_d = 1'b1;
        end else if (bus.fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        gap_d   = gap_q;
        if (fault_q || bus.fault || !bus.enable) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_GAP;
                    gap_d   = GAP_LOAD;
                    dir_d   = bus.dir;
                end
                ST_GAP: begin
                    if (bus.dir != dir_q) begin
                        dir_d = bus.dir;
                        gap_d = GAP_LOAD;
                    end else if (gap_q == 8'd0) begin
                        state_d = bus.brake ? ST_BRAKE : ST_RUN;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                ST_RUN: begin
                    if (bus.brake) begin
                        state_d = ST_BRAKE;
                    end else if (bus.dir != dir_q) begin
                        state_d = ST_GAP;
                        dir_d   = bus.dir;
                        gap_d   = GAP_LOAD;
                    end
                end
                ST_BRAKE: begin
                    if (!bus.brake) begin
                        if (bus.dir == dir_q) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_GAP;
                            dir_d   = bus.dir;
                            gap_d   = GAP_LOAD;
                        end
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Leg commands follow the next state so a fault or reversal blanks the gates at the same edge.
    always_comb begin
        a_cmd = LEG_Z;
        b_cmd = LEG_Z;
        case (state_d)
            ST_RUN: begin
                if (!dir_d) begin
                    a_cmd = bus.pwm_in ? LEG_H : LEG_L;
                    b_cmd = LEG_L;
                end else begin
                    a_cmd = LEG_L;
                    b_cmd = bus.pwm_in ? LEG_H : LEG_L;
                end
            end
            ST_BRAKE: begin
                a_cmd = LEG_L;
                b_cmd = LEG_L;
            end
            default: begin
                a_cmd = LEG_Z;
                b_cmd = LEG_Z;
            end
        endcase
        a_d = leg_step(a_cmd, a_q);
        b_d = leg_step(b_cmd, b_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            dir_q   <= 1'b0;
            gap_q   <= 8'd0;
            fault_q <= 1'b0;
            a_q     <= '{out: LEG_Z, dt: 4'd0};
            b_q     <= '{out: LEG_Z, dt: 4'd0};
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            gap_q   <= gap_d;
            fault_q <= fault_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign bus.a_hi          = a_q.out[1];
    assign bus.a_lo          = a_q.out[0];
    assign bus.b_hi          = b_q.out[1];
    assign bus.b_lo          = b_q.out[0];
    assign bus.state         = state_q;
    assign bus.fault_latched = fault_q;

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Directed bench for hbridge_deadtime (DEADTIME=2, DIR_GAP=8): gates packed as {a_hi,a_lo,b_hi,b_lo}.
module tb_hbridge_deadtime;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    hbridge_deadtime_if bus ();

    hbridge_deadtime #(
        .DEADTIME(2),
        .DIR_GAP (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gates();
        return {4'd0, bus.a_hi, bus.a_lo, bus.b_hi, bus.b_lo};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge, settle, and check the shoot-through invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("shoot_through", {5'd0, bus.a_hi & bus.a_lo, bus.b_hi & bus.b_lo, bus.a_hi & bus.b_hi}, 8'd0);
    endtask

    task automatic chk_sg(input string tag, input logic [1:0] st, input logic [3:0] g);
        chk({tag, "_state"}, {6'd0, bus.state}, {6'd0, st});
        chk({tag, "_gates"}, gates(), {4'd0, g});
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        bus.pwm_in = 1'b0; bus.enable = 1'b0; bus.dir = 1'b0;
        bus.brake = 1'b0; bus.fault = 1'b0; bus.fault_clr = 1'b0;

        // T1 reset
        tick();
        tick();
        chk_sg("reset", 2'd0, 4'b0000);
        chk("reset_fault", {7'd0, bus.fault_latched}, 8'd0);
        rst_n = 1'b1;
        tick();
        chk_sg("idle", 2'd0, 4'b0000);

        // T2 start-up gap then RUN with both lows on
        bus.enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_sg("startup_gap", 2'd2, 4'b0000);
        end
        tick();
        chk_sg("startup_run", 2'd1, 4'b0101);

        // T3 PWM edges with dead time
        bus.pwm_in = 1'b1;
        tick(); chk_sg("rise_k", 2'd1, 4'b0001);
        tick(); chk_sg("rise_k1", 2'd1, 4'b0001);
        tick(); chk_sg("rise_k2", 2'd1, 4'b1001);
        tick(); chk_sg("rise_hold", 2'd1, 4'b1001);
        bus.pwm_in = 1'b0;
        tick(); chk_sg("fall_j", 2'd1, 4'b0001);
        tick(); chk_sg("fall_j1", 2'd1, 4'b0001);
        tick(); chk_sg("fall_j2", 2'd1, 4'b0101);

        // T4 narrow pulse is swallowed
        bus.pwm_in = 1'b1;
        tick(); chk_sg("narrow_0", 2'd1, 4'b0001);
        bus.pwm_in = 1'b0;
        tick(); chk_sg("narrow_1", 2'd1, 4'b0001);
        tick(); chk_sg("narrow_2", 2'd1, 4'b0101);
        tick(); chk_sg("narrow_3", 2'd1, 4'b0101);

        // T5 reversal to dir=1, B leg switched
        bus.dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_sg("rev_gap", 2'd2, 4'b0000);
        end
        tick(); chk_sg("rev_run", 2'd1, 4'b0101);
        bus.pwm_in = 1'b1;
        tick(); chk_sg("rev_rise_k", 2'd1, 4'b0100);
        tick(); chk_sg("rev_rise_k1", 2'd1, 4'b0100);
        tick(); chk_sg("rev_rise_k2", 2'd1, 4'b0110);
        bus.pwm_in = 1'b0;
        tick(); chk_sg("rev_fall_j", 2'd1, 4'b0100);
        tick(); chk_sg("rev_fall_j1", 2'd1, 4'b0100);
        tick(); chk_sg("rev_fall_j2", 2'd1, 4'b0101);

        // Mid-gap direction toggle restarts the gap count
        bus.dir = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_sg("toggle_gap_a", 2'd2, 4'b0000);
        end
        bus.dir = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_sg("toggle_gap_b", 2'd2, 4'b0000);
        end
        tick(); chk_sg("toggle_run", 2'd1, 4'b0101);

        // T6 fault latch, priority over clear, then recovery
        bus.fault = 1'b1;
        tick(); chk_sg("fault_set", 2'd0, 4'b0000);
        chk("fault_set_fl", {7'd0, bus.fault_latched}, 8'd1);
        bus.fault_clr = 1'b1;
        tick(); chk("fault_prio_fl", {7'd0, bus.fault_latched}, 8'd1);
        bus.fault = 1'b0;
        bus.fault_clr = 1'b0;
        tick(); chk_sg("fault_hold", 2'd0, 4'b0000);
        chk("fault_hold_fl", {7'd0, bus.fault_latched}, 8'd1);
        bus.fault_clr = 1'b1;
        tick(); chk_sg("fault_clr", 2'd0, 4'b0000);
        chk("fault_clr_fl", {7'd0, bus.fault_latched}, 8'd0);
        bus.fault_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_sg("recover_gap", 2'd2, 4'b0000);
        end
        tick(); chk_sg("recover_run", 2'd1, 4'b0101);

        // Back to forward, drive high, then brake
        bus.dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_sg("fwd_gap", 2'd2, 4'b0000);
        end
        tick(); chk_sg("fwd_run", 2'd1, 4'b0101);
        bus.pwm_in = 1'b1;
        tick(); tick(); tick();
        chk_sg("fwd_high", 2'd1, 4'b1001);
        bus.brake = 1'b1;
        tick(); chk_sg("brake_k", 2'd3, 4'b0001);
        tick(); chk_sg("brake_k1", 2'd3, 4'b0001);
        tick(); chk_sg("brake_k2", 2'd3, 4'b0101);
        bus.brake = 1'b0;
        tick(); chk_sg("unbrake", 2'd1, 4'b0001);
        tick(); tick();
        chk_sg("unbrake_high", 2'd1, 4'b1001);

        // Coast: enable low blanks all gates at once
        bus.enable = 1'b0;
        tick(); chk_sg("coast", 2'd0, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
